// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code set 2 assembler with modifier tracking and an event FIFO.
// Define PS2_PAUSE_EN to collapse the 8-byte E1 Pause sequence into one event.
module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 500000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        rx_done,
    input  logic [7:0]                  rx_data,
    output logic                        ev_valid,
    output logic [9:0]                  ev_data,
    input  logic                        ev_ack,
    output logic [$clog2(FIFO_DEPTH):0] ev_count,
    output logic [3:0]                  mods,
    output logic                        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] EXT     = 3'd1;
    localparam logic [2:0] BRK     = 3'd2;
    localparam logic [2:0] EXT_BRK = 3'd3;
`ifdef PS2_PAUSE_EN
    localparam logic [2:0] PAUSE   = 3'd4;
    logic [2:0] pcnt;
`endif

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [TW-1:0] timer;
    logic          tmo_hit;
    logic          emit;
    logic [9:0]    ev_new;
    logic          is_reply;
    logic          is_fake;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          wr;

    assign is_reply = (rx_data == 8'hFA) || (rx_data == 8'hAA) ||
                      (rx_data == 8'hEE) || (rx_data == 8'hFE) ||
                      (rx_data == 8'h00) || (rx_data == 8'hFF);
    assign is_fake  = (rx_data == 8'h12) || (rx_data == 8'h59);
    assign tmo_hit  = (state != IDLE) && (timer == TW'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        emit     = 1'b0;
        ev_new   = {2'b00, rx_data};
        if (rx_done) begin
            case (state)
                IDLE: begin
                    if (rx_data == 8'hE0) state_nx = EXT;
                    else if (rx_data == 8'hF0) state_nx = BRK;
`ifdef PS2_PAUSE_EN
                    else if (rx_data == 8'hE1) state_nx = PAUSE;
`endif
                    else if (!is_reply) emit = 1'b1;
                end
                EXT: begin
                    if (rx_data == 8'hF0) state_nx = EXT_BRK;
                    else if (rx_data != 8'hE0) begin
                        state_nx = IDLE;
                        emit     = !is_fake;
                        ev_new   = {2'b01, rx_data};
                    end
                end
                BRK: begin
                    state_nx = IDLE;
                    emit     = 1'b1;
                    ev_new   = {2'b10, rx_data};
                end
                EXT_BRK: begin
                    state_nx = IDLE;
                    emit     = !is_fake;
                    ev_new   = {2'b11, rx_data};
                end
`ifdef PS2_PAUSE_EN
                PAUSE: begin
                    if (pcnt == 3'd6) begin
                        state_nx = IDLE;
                        emit     = 1'b1;
                        ev_new   = {2'b01, 8'h77};
                    end
                end
`endif
                default: state_nx = IDLE;
            endcase
        end else if (tmo_hit) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nx;
            if (rx_done || state == IDLE || tmo_hit) timer <= '0;
            else timer <= timer + TW'(1);
        end
    end

`ifdef PS2_PAUSE_EN
    always_ff @(posedge clock) begin
        if (reset) pcnt <= '0;
        else if (rx_done && state == IDLE) pcnt <= '0;
        else if (rx_done && state == PAUSE) pcnt <= pcnt + 3'd1;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            mods <= '0;
        end else if (emit) begin
            if (!ev_new[8] && ev_new[7:0] == 8'h12) mods[0] <= !ev_new[9];
            if (!ev_new[8] && ev_new[7:0] == 8'h59) mods[1] <= !ev_new[9];
            if (ev_new[7:0] == 8'h14) mods[2] <= !ev_new[9];
            if (ev_new[7:0] == 8'h11) mods[3] <= !ev_new[9];
        end
    end

    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = ev_valid && ev_ack;
    assign wr       = emit && (!full || pop);
    assign ev_valid = (count != '0);
    assign ev_count = count;

    always_ff @(posedge clock) begin
        if (wr) mem[wptr] <= ev_new;
    end

    // ev_data is a register so it keeps the last popped entry once empty
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            ev_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            if (wr && !pop) count <= count + CW'(1);
            else if (pop && !wr) count <= count - CW'(1);
            if (emit && full && !pop) overflow <= 1'b1;
            if (wr && (count == '0 || (pop && count == CW'(1))))
                ev_data <= ev_new;
            else if (pop && count > CW'(1))
                ev_data <= mem[rptr + AW'(1)];
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Randomized bench for ps2_kbd_ctrl against a prefix/queue reference model.
// Handles both PS2_PAUSE_EN builds.
module tb_ps2_kbd_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 64;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       ev_ack = 1'b0;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic [3:0] ev_count;
    logic [3:0] mods;
    logic       overflow;

    ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
        .ev_valid(ev_valid), .ev_data(ev_data), .ev_ack(ev_ack),
        .ev_count(ev_count), .mods(mods), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    logic [9:0] q[$];
    logic [9:0] last_pop;
    logic [3:0] m_mods;
    logic       m_ovf;
    bit         have_e0, have_f0;
    int         pause_left;
    int         cyc = 0;
    int         last_byte = 0;

    // One clock edge of the reference model, given the inputs applied to it.
    task automatic m_step(input bit rst, input bit d, input logic [7:0] b,
                          input bit a);
        bit         e = 0;
        logic [9:0] ev = '0;
        bit         rel, ext, full, popn;
        cyc++;
        if (rst) begin
            q.delete();
            last_pop = '0; m_mods = '0; m_ovf = 0;
            have_e0 = 0; have_f0 = 0; pause_left = 0;
            return;
        end
        if (d) begin
            if ((have_e0 || have_f0 || pause_left > 0) && cyc - last_byte > TMO) begin
                have_e0 = 0; have_f0 = 0; pause_left = 0;
            end
            last_byte = cyc;
            if (pause_left > 0) begin
                pause_left--;
                if (pause_left == 0) begin e = 1; ev = 10'h177; end
            end else if (b == 8'hE0 && !have_f0) begin
                have_e0 = 1;
            end else if (b == 8'hF0 && !have_f0) begin
                have_f0 = 1;
`ifdef PS2_PAUSE_EN
            end else if (b == 8'hE1 && !have_e0 && !have_f0) begin
                pause_left = 7;
`endif
            end else begin
                rel = have_f0; ext = have_e0;
                have_e0 = 0; have_f0 = 0;
                if (!ext && !rel && (b == 8'hFA || b == 8'hAA || b == 8'hEE ||
                                     b == 8'hFE || b == 8'h00 || b == 8'hFF))
                    e = 0;
                else if (ext && (b == 8'h12 || b == 8'h59))
                    e = 0;
                else begin
                    e = 1; ev = {rel, ext, b};
                end
            end
        end
        full = (q.size() == DEPTH);
        popn = a && q.size() > 0;
        if (popn) last_pop = q.pop_front();
        if (e) begin
            if (!full || popn) q.push_back(ev);
            else m_ovf = 1;
            if (!ev[8] && ev[7:0] == 8'h12) m_mods[0] = !ev[9];
            if (!ev[8] && ev[7:0] == 8'h59) m_mods[1] = !ev[9];
            if (ev[7:0] == 8'h14) m_mods[2] = !ev[9];
            if (ev[7:0] == 8'h11) m_mods[3] = !ev[9];
        end
    endtask

    task automatic check_all();
        check("ev_valid", ev_valid, q.size() != 0);
        check("ev_count", ev_count, q.size());
        check("ev_data", ev_data, q.size() != 0 ? q[0] : last_pop);
        check("mods", mods, m_mods);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic step(input bit rst, input bit d, input logic [7:0] b,
                        input bit a);
        @(negedge clock);
        check_all();
        reset = rst; rx_done = d; rx_data = b; ev_ack = a;
        m_step(rst, d, b, a);
    endtask

    task automatic send(input logic [7:0] b, input bit a);
        step(0, 1, b, a);
    endtask

    task automatic idle(input int n, input bit a);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, a);
    endtask

    logic [7:0] bs[$];

    task automatic play();
        foreach (bs[i]) begin
            send(bs[i], 0);
            idle(1, 0);
        end
    endtask

    logic [7:0] pick[12];

    initial begin
        m_step(1, 0, 8'h00, 0);
        repeat (2) @(posedge clock);
        step(1, 0, 8'h00, 0);

        bs = '{8'h1C, 8'hF0, 8'h1C};
        play(); idle(DEPTH + 2, 1);
        bs = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12, 8'h1C};
        play(); idle(DEPTH + 2, 1);
        bs = '{8'h12, 8'h14, 8'hF0, 8'h12};
        play(); idle(DEPTH + 2, 1);

        bs = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43};
        play();
        send(8'h44, 1);
        idle(1, 0);
        send(8'h4B, 0);
        idle(2, 0);
        idle(DEPTH + 2, 1);
        step(1, 0, 8'h00, 0);

        send(8'hF0, 0); idle(TMO - 1, 0); send(8'h1C, 0);
        send(8'hF0, 0); idle(TMO, 0);     send(8'h1C, 0);
        send(8'hE0, 0); idle(TMO, 0);     send(8'h12, 0);
        send(8'hE0, 0); idle(TMO - 1, 0); send(8'h14, 0);
        idle(DEPTH + 2, 1);

        send(8'hF0, 0);
        step(1, 0, 8'h00, 0);
        send(8'h1C, 0);
        idle(3, 1);

        bs = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        play(); idle(DEPTH + 2, 1);

        pick = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h14, 8'h11,
                 8'h1C, 8'hFA, 8'hAA, 8'hE1, 8'h77, 8'h00};
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 15);
            b = (r < 12) ? pick[r] : 8'($urandom);
            if ($urandom_range(0, 199) == 0) step(1, 0, 8'h00, 0);
            send(b, 1'($urandom));
            if ($urandom_range(0, 19) == 0)
                idle(TMO - 1 + $urandom_range(0, 2), 1'($urandom));
            else
                idle($urandom_range(0, 2), ($urandom_range(0, 2) == 0));
        end
        idle(DEPTH + 2, 1);
        @(negedge clock);
        check_all();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Keyboard protocol controller that sits directly behind the PS/2 byte receiver.
- Consumes its one-cycle `done` strobe and `data` byte, and assembles scan-code set 2 sequences (E0 extended prefix, F0 break prefix) into single key events.
- Tracks modifier state and buffers events in a small FIFO, which the CPU/port logic drains with a valid/ack handshake.
- Recovers from truncated sequences with an inter-byte timeout.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2.
- TIMEOUT, 500000, idle cycles allowed between bytes of one sequence (20 ms at 25 MHz).

Ports:
- clock  in  1  system clock, 25 MHz
- reset  in  1  synchronous, active-high reset
- rx_done  in  1  one-cycle strobe: rx_data holds a valid received byte
- rx_data  in  8  received byte from the PS/2 receiver
- ev_valid  out  1  FIFO non-empty; ev_data is valid
- ev_data  out  10  head event {release, extended, code[7:0]}
- ev_ack  in  1  pop the head event; ignored when ev_valid=0
- ev_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- mods  out  4  {alt, ctrl, rshift, lshift}, 1 = held
- overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
Clock and reset
- One clock domain, synchronous active-high reset.
- Reset values: state IDLE, timer 0, FIFO empty, ev_valid 0, ev_data 0, ev_count 0, mods 0, overflow 0.
- Reset mid-sequence discards the partial sequence. The next non-prefix byte is emitted as a plain make.

Assembler FSM (advances only on rx_done=1)
- IDLE:
  - E0 -> EXT; F0 -> BRK.
  - FA, AA, EE, FE, 00, FF: dropped, stay in IDLE (device replies and errors).
  - Any other byte: emit {0,0,byte}, stay in IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay in EXT.
  - Byte 12 or 59 (fake shift): dropped, -> IDLE.
  - Any other byte: emit {0,1,byte}, -> IDLE.
- BRK: any byte -> emit {1,0,byte}, -> IDLE.
- EXT_BRK:
  - Byte 12 or 59: dropped, -> IDLE.
  - Any other byte: emit {1,1,byte}, -> IDLE.

Timeout
- Timer clears on rx_done and in IDLE.
- Otherwise the timer increments each cycle. When it reaches TIMEOUT-1, the FSM returns to IDLE and the timer clears; nothing is emitted.

Modifiers
- Updated in the same cycle as an emit, regardless of FIFO space.
- Code 12, non-extended: lshift. Code 59, non-extended: rshift. Code 14, either: ctrl. Code 11, either: alt.
- Make sets the bit; break clears it.

FIFO
- Emit pushes the event; ev_valid && ev_ack pops.
- Latency: rx_done in cycle N with an empty FIFO gives ev_valid=1 and the event on ev_data in cycle N+1 (registered).
- Full, with pop and push in the same cycle: both happen, count unchanged, no overflow.
- Full, push without pop: event dropped, overflow set (cleared only by reset).
- Empty: ev_ack is ignored and the count does not underflow.
- Pointers wrap modulo FIFO_DEPTH.
- ev_data holds its value while ev_valid=0 (last popped entry or 0).

Optional Feature:
PS2_PAUSE_EN
- Defined:
  - E1 received in IDLE enters PAUSE and loads a 3-bit byte counter.
  - The next 7 bytes are consumed unconditionally; the expected sequence is 14 77 E1 F0 14 F0 77.
  - After the 7th byte, emit {0,1,8'h77} and return to IDLE. No break event is generated.
  - The timeout applies in PAUSE.
- Not defined: E1 is an ordinary byte; the PAUSE state and its counter are not synthesized.

Test Plan:
- Bytes 1C, then F0 1C -> events 01C, then 21C; ev_valid rises in the cycle after each completing rx_done.
- Bytes E0 75, E0 F0 75 -> events 175, 375; E0 12 -> no event, state IDLE.
- Bytes 12, 14, then F0 12 -> mods goes 0001, then 0101, then 0100; three events.
- 9 make codes with no ev_ack and FIFO_DEPTH=8 -> ev_count=8, overflow=1, head event = 1st code.
- With ev_count=8, push and ack in the same cycle -> ev_count stays 8 and overflow stays 0.
- Byte F0, idle 500000 cycles, then byte 1C -> event 01C (make); with PS2_PAUSE_EN, E1 14 77 E1 F0 14 F0 77 -> single event 177.
